// File: rtl/scene_sequencer.sv
// Frame-rate title/gameplay sequencer: countdown, logo scroll-out, head slide-in,
// then lane selection from buttons and coin scrolling, all stepped once per vsync.
module scene_sequencer #(
    parameter int COUNTDOWN_FRAMES = 5,
    parameter int LOGO_STEP        = 30,
    parameter int LOGO_LIMIT       = -600,
    parameter int HEAD_START       = -170,
    parameter int HEAD_STEP        = 17,
    parameter int LANE_OFFSET      = 100,
    parameter int COIN_WRAP        = 80
) (
    input  logic               CPU_RESETN,
    input  logic               CLK100MHZ,
    input  logic               vsync,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic               frame_tick,
    output logic [1:0]         state,
    output logic               playing,
    output logic signed [11:0] logo_voffset,
    output logic signed [11:0] head_hoffset,
    output logic signed [11:0] head_voffset,
    output logic signed [11:0] coin_pos
);

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_LOGO  = 2'd1,
        ST_HEAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LANE_LEFT   = 2'd0,
        LANE_CENTER = 2'd1,
        LANE_RIGHT  = 2'd2
    } lane_t;

    localparam logic [7:0]         COUNT_INIT   = 8'(COUNTDOWN_FRAMES);
    localparam logic signed [12:0] LOGO_STEP_W  = 13'(LOGO_STEP);
    localparam logic signed [12:0] LOGO_LIMIT_W = 13'(LOGO_LIMIT);
    localparam logic signed [11:0] HEAD_START_W = 12'(HEAD_START);
    localparam logic signed [12:0] HEAD_STEP_W  = 13'(HEAD_STEP);
    localparam logic signed [11:0] LANE_OFF_W   = 12'(LANE_OFFSET);
    localparam logic [11:0]        COIN_WRAP_W  = 12'(COIN_WRAP);

    function automatic logic signed [11:0] lane_offset(input lane_t lane);
        case (lane)
            LANE_LEFT:  lane_offset = -LANE_OFF_W;
            LANE_RIGHT: lane_offset = LANE_OFF_W;
            default:    lane_offset = 12'sd0;
        endcase
    endfunction

    state_t             state_q, state_d;
    lane_t              lane_q, lane_d;
    logic               vsync_q, vsync_d;
    logic               frame_tick_q, frame_tick_d;
    logic               bl_meta_q, bl_meta_d, bl_sync_q, bl_sync_d, bl_prev_q, bl_prev_d;
    logic               br_meta_q, br_meta_d, br_sync_q, br_sync_d, br_prev_q, br_prev_d;
    logic               pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic               playing_q, playing_d;
    logic [7:0]         count_q, count_d;
    logic signed [11:0] logo_q, logo_d;
    logic signed [11:0] head_v_q, head_v_d;
    logic signed [11:0] head_h_q, head_h_d;
    logic [11:0]        coin_q, coin_d;
    logic               edge_l_s, edge_r_s;
    logic signed [12:0] logo_diff_s, head_sum_s;
    logic [11:0]        coin_inc_s;

    // Next-state computation: every offset and state change is gated by the registered frame tick.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        count_d      = count_q;
        logo_d       = logo_q;
        head_v_d     = head_v_q;
        coin_d       = (state_q == ST_RUN) ? coin_q : 12'd0;
        vsync_d      = vsync;
        frame_tick_d = vsync & ~vsync_q;
        bl_meta_d    = btn_left;
        bl_sync_d    = bl_meta_q;
        bl_prev_d    = bl_sync_q;
        br_meta_d    = btn_right;
        br_sync_d    = br_meta_q;
        br_prev_d    = br_sync_q;
        edge_l_s     = bl_sync_q & ~bl_prev_q;
        edge_r_s     = br_sync_q & ~br_prev_q;
        logo_diff_s  = {logo_q[11], logo_q} - LOGO_STEP_W;
        head_sum_s   = {head_v_q[11], head_v_q} + HEAD_STEP_W;
        coin_inc_s   = coin_q + 12'd1;

        // An edge arriving on the tick cycle survives the clear and lands on the next frame.
        if (state_q == ST_RUN) begin
            if (frame_tick_q) begin
                pend_l_d = edge_l_s;
                pend_r_d = edge_r_s;
            end else begin
                pend_l_d = pend_l_q | edge_l_s;
                pend_r_d = pend_r_q | edge_r_s;
            end
        end else begin
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
        end

        if (frame_tick_q) begin
            case (state_q)
                ST_COUNT: begin
                    if (count_q != 8'd0) begin
                        count_d = count_q - 8'd1;
                    end else begin
                        state_d = ST_LOGO;
                    end
                end
                ST_LOGO: begin
                    if (logo_diff_s <= LOGO_LIMIT_W) begin
                        logo_d  = LOGO_LIMIT_W[11:0];
                        state_d = ST_HEAD;
                    end else begin
                        logo_d = logo_diff_s[11:0];
                    end
                end
                ST_HEAD: begin
                    if (head_sum_s >= 13'sd0) begin
                        head_v_d = 12'sd0;
                        state_d  = ST_RUN;
                    end else begin
                        head_v_d = head_sum_s[11:0];
                    end
                end
                ST_RUN: begin
                    coin_d = (coin_inc_s == COIN_WRAP_W) ? 12'd0 : coin_inc_s;
                    if (pend_l_q && !pend_r_q) begin
                        case (lane_q)
                            LANE_RIGHT: lane_d = LANE_CENTER;
                            default:    lane_d = LANE_LEFT;
                        endcase
                    end else if (pend_r_q && !pend_l_q) begin
                        case (lane_q)
                            LANE_LEFT: lane_d = LANE_CENTER;
                            default:   lane_d = LANE_RIGHT;
                        endcase
                    end else begin
                        lane_d = lane_q;
                    end
                end
                default: begin
                    state_d = ST_COUNT;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        head_h_d  = lane_offset(lane_d);
        playing_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_COUNT;
            lane_q       <= LANE_CENTER;
            count_q      <= COUNT_INIT;
            logo_q       <= 12'sd0;
            head_v_q     <= HEAD_START_W;
            head_h_q     <= 12'sd0;
            coin_q       <= 12'd0;
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            bl_meta_q    <= 1'b0;
            bl_sync_q    <= 1'b0;
            bl_prev_q    <= 1'b0;
            br_meta_q    <= 1'b0;
            br_sync_q    <= 1'b0;
            br_prev_q    <= 1'b0;
            pend_l_q     <= 1'b0;
            pend_r_q     <= 1'b0;
            playing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            count_q      <= count_d;
            logo_q       <= logo_d;
            head_v_q     <= head_v_d;
            head_h_q     <= head_h_d;
            coin_q       <= coin_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
            bl_meta_q    <= bl_meta_d;
            bl_sync_q    <= bl_sync_d;
            bl_prev_q    <= bl_prev_d;
            br_meta_q    <= br_meta_d;
            br_sync_q    <= br_sync_d;
            br_prev_q    <= br_prev_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            playing_q    <= playing_d;
        end
    end

    assign frame_tick   = frame_tick_q;
    assign state        = state_q;
    assign playing      = playing_q;
    assign logo_voffset = logo_q;
    assign head_hoffset = head_h_q;
    assign head_voffset = head_v_q;
    assign coin_pos     = coin_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer: walks the title sequence into gameplay,
// exercises lane changes, coin wrap and a mid-sequence reset.
module tb_scene_sequencer;

    logic               clk;
    logic               rst_n;
    logic               vsync;
    logic               btn_left;
    logic               btn_right;
    logic               frame_tick;
    logic [1:0]         state;
    logic               playing;
    logic signed [11:0] logo_voffset;
    logic signed [11:0] head_hoffset;
    logic signed [11:0] head_voffset;
    logic signed [11:0] coin_pos;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;
    int exp_coin = 0;

    scene_sequencer dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .vsync        (vsync),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .frame_tick   (frame_tick),
        .state        (state),
        .playing      (playing),
        .logo_voffset (logo_voffset),
        .head_hoffset (head_hoffset),
        .head_voffset (head_voffset),
        .coin_pos     (coin_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_tick === 1'b1) tick_cnt <= tick_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: vsync low then rising; returns after the tick-gated update has settled.
    task automatic do_tick();
        @(negedge clk) vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic l, input logic r);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        repeat (4) @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_tick();
        do_tick();
        exp_coin = (exp_coin + 1) % 80;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_playing"}, 32'(playing), 0);
        check({tag, "_logo"}, logo_voffset, 0);
        check({tag, "_headv"}, head_voffset, -170);
        check({tag, "_headh"}, head_hoffset, 0);
        check({tag, "_coin"}, coin_pos, 0);
        check({tag, "_tick"}, 32'(frame_tick), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        vsync     = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_tick_vsync_high", tick_cnt, 0);
        check_reset_values("rst");

        // Countdown, with presses that must be discarded
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) press(1'b1, 1'b0);
            do_tick();
            check("count_state", 32'(state), 0);
        end
        do_tick();
        check("logo_entry_state", 32'(state), 1);
        check("logo_entry_offset", logo_voffset, 0);
        check("tick_count_6", tick_cnt, 6);

        for (int k = 1; k <= 20; k++) begin
            if (k == 3) press(1'b0, 1'b1);
            do_tick();
            check("logo_voffset", logo_voffset, -30 * k);
            check("logo_state", 32'(state), (k == 20) ? 2 : 1);
        end

        for (int k = 1; k <= 10; k++) begin
            do_tick();
            check("head_voffset", head_voffset, (k == 10) ? 0 : -170 + 17 * k);
            check("head_state", 32'(state), (k == 10) ? 3 : 2);
            check("head_playing", 32'(playing), (k == 10) ? 1 : 0);
        end
        check("run_entry_headh", head_hoffset, 0);
        check("run_entry_logo", logo_voffset, -600);
        check("run_entry_coin", coin_pos, 0);
        exp_coin = 0;

        run_tick();
        check("no_stale_press", head_hoffset, 0);
        press(1'b1, 1'b0);
        run_tick();
        check("left_once", head_hoffset, -100);
        press(1'b1, 1'b0);
        run_tick();
        check("left_saturate", head_hoffset, -100);
        press(1'b0, 1'b1);
        run_tick();
        check("right_to_center", head_hoffset, 0);
        press(1'b1, 1'b1);
        run_tick();
        check("both_no_move", head_hoffset, 0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        run_tick();
        check("double_right_one_step", head_hoffset, 100);
        press(1'b0, 1'b1);
        run_tick();
        check("right_saturate", head_hoffset, 100);
        check("coin_track", coin_pos, exp_coin);

        for (int k = 0; k < 80; k++) begin
            run_tick();
            check("coin_pos", coin_pos, exp_coin);
        end
        check("run_playing", 32'(playing), 1);

        // Back to LOGO, then a single-cycle reset with a press in flight
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check_reset_values("rst2");
        for (int k = 0; k < 9; k++) do_tick();
        check("mid_logo_state", 32'(state), 1);
        check("mid_logo_offset", logo_voffset, -90);
        @(negedge clk) btn_left = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        btn_left = 1'b0;
        check_reset_values("rst3");
        for (int k = 0; k < 36; k++) do_tick();
        check("rerun_state", 32'(state), 3);
        do_tick();
        check("rerun_headh", head_hoffset, 0);
        check("rerun_coin", coin_pos, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
Frame-rate game controller that sequences the title-screen animation (countdown, logo scroll-out, head slide-in) and then runs gameplay: lane selection from the left/right buttons and the coin scroll position. It sits between the board buttons/VGA vsync and the sprite layer stack, driving the per-layer hoffset/voffset values. All state advances once per video frame.

Parameters:
COUNTDOWN_FRAMES, 5, frames held on the static title before the logo moves (1..255)
LOGO_STEP, 30, logo voffset decrement per frame (>0)
LOGO_LIMIT, -600, final logo voffset (negative, 12-bit signed)
HEAD_START, -170, head voffset at reset (negative)
HEAD_STEP, 17, head voffset increment per frame (>0)
LANE_OFFSET, 100, head hoffset magnitude for the side lanes
COIN_WRAP, 80, coin_pos modulus (2..2047)

Ports:
CLK100MHZ  input  1  system clock
CPU_RESETN  input  1  synchronous active-low reset
vsync  input  1  VGA vertical sync from the timing generator, synchronous to CLK100MHZ
btn_left  input  1  raw left button, asynchronous
btn_right  input  1  raw right button, asynchronous
frame_tick  output  1  one-cycle pulse per frame (vsync rising edge)
state  output  2  0 COUNT, 1 LOGO, 2 HEAD, 3 RUN
playing  output  1  high in RUN
logo_voffset  output  12 signed  logo layer voffset
head_hoffset  output  12 signed  head layer hoffset (lane)
head_voffset  output  12 signed  head layer voffset
coin_pos  output  12 signed  coin scroll position

Behaviour:
- Reset (CPU_RESETN=0 at a CLK100MHZ edge, any state): state=COUNT, count=COUNTDOWN_FRAMES, logo_voffset=0, head_voffset=HEAD_START, head_hoffset=0, lane=CENTER, coin_pos=0, pending requests cleared, frame_tick=0, playing=0, vsync_q=1 (no spurious tick if vsync is high out of reset), button sync/edge regs=0.
- frame_tick: registered; vsync_q tracks vsync; frame_tick=vsync & ~vsync_q, high exactly one cycle per rising edge.
- All state/offset updates occur only on edges where frame_tick=1; outputs are registered and hold otherwise.
- COUNT: tick with count>0 -> count-1. Tick with count=0 -> LOGO (no offset change that tick). Entry to LOGO occurs on tick COUNTDOWN_FRAMES+1.
- LOGO: tick -> logo_voffset = max(logo_voffset-LOGO_STEP, LOGO_LIMIT), saturating, no overshoot. If the new value equals LOGO_LIMIT, go to HEAD on the same edge.
- HEAD: tick -> head_voffset = min(head_voffset+HEAD_STEP, 0), saturating. If the new value is 0, go to RUN on the same edge.
- RUN: playing=1. On tick, coin_pos = (coin_pos+1 == COIN_WRAP) ? 0 : coin_pos+1. Outside RUN, coin_pos holds 0.
- Buttons: 2-FF synchroniser, then rising-edge detect. A detected edge sets pend_l/pend_r (sticky). Edges outside RUN are discarded, so pend stays 0.
- Lane update on a RUN tick, then pending cleared on the same edge:
  - pend_l only: lane moves one step left, saturating at LEFT.
  - pend_r only: lane moves one step right, saturating at RIGHT.
  - both: no move.
  - An edge detected on the same cycle as the tick is captured for the next tick, not lost.
- head_hoffset = -LANE_OFFSET / 0 / +LANE_OFFSET for LEFT/CENTER/RIGHT, updated on the same edge as lane.
- Multiple presses of one button within a frame count as one step.
- Arithmetic is 12-bit signed. Parameters must keep every intermediate within -2048..2047; compute the saturation compare before truncation.
- state is never 3 unless logo_voffset=LOGO_LIMIT and head_voffset=0.

Test Plan:
- Reset, vsync held high -> frame_tick never pulses. All outputs at reset values: state=0, logo_voffset=0, head_voffset=-170, head_hoffset=0, coin_pos=0.
- 6 vsync rising edges -> state=1 after the 6th tick. logo_voffset reaches -600 after 20 further ticks and state=2 on that same tick.
- Continue 10 ticks -> head_voffset steps -153, -136, ..., 0. state=3 and playing=1 on the 10th tick.
- RUN, pulse btn_left mid-frame -> head_hoffset=-100 after the next tick. Second left press -> stays -100. Right press -> 0. Both pressed in one frame -> unchanged.
- RUN, 80 ticks -> coin_pos counts 1..79 then 0. Presses during COUNT/LOGO -> head_hoffset stays 0 on entering RUN.
- Assert CPU_RESETN=0 for one cycle mid-LOGO with a pending press -> next edge restores all reset values and the pending press is dropped.
